// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the shared data memory port: core (port 0) has fixed
// priority, loader/debug (port 1) is protected by a starvation counter and a lock mode.
module data_mem_arbiter #(
  parameter int unsigned MAX_WAIT   = 4,
  parameter bit          P1_LOCK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic [3:0]  p0_wr_sel,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wr_data,
  output logic        p0_gnt,
  output logic        p0_rd_valid,
  output logic [31:0] p0_rd_data,
  input  logic        p1_req,
  input  logic [3:0]  p1_wr_sel,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wr_data,
  output logic        p1_gnt,
  output logic        p1_rd_valid,
  output logic [31:0] p1_rd_data,
  input  logic        p1_lock,
  output logic [3:0]  mem_wr_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  // state | meaning
  // ARB   | port 0 fixed priority, port 1 force-granted once wait_cnt hits MAX_WAIT
  // LOCK1 | port 1 owns the memory while p1_lock stays high
  typedef enum logic {ARB, LOCK1} state_t;

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  state_t     r_state;
  logic [3:0] r_wait_cnt;
  logic       r_rd_pend;
  logic       r_rd_pend_port;
  logic       w_p0_gnt;
  logic       w_p1_gnt;
  logic       w_rd_grant;

  always_comb begin
    w_p0_gnt = 1'b0;
    w_p1_gnt = 1'b0;
    if (!rst) begin
      if (r_state == LOCK1 && p1_lock) begin
        w_p1_gnt = p1_req;
      end else if (r_wait_cnt == LP_MAX_WAIT && p1_req) begin
        w_p1_gnt = 1'b1;
      end else if (p0_req) begin
        w_p0_gnt = 1'b1;
      end else if (p1_req) begin
        w_p1_gnt = 1'b1;
      end
    end
  end

  assign p0_gnt = w_p0_gnt;
  assign p1_gnt = w_p1_gnt;

  // Idle port is driven to zero so the memory never sees a stray write.
  always_comb begin
    mem_wr_sel  = 4'b0;
    mem_addr    = 32'b0;
    mem_wr_data = 32'b0;
    if (w_p0_gnt) begin
      mem_wr_sel  = p0_wr_sel;
      mem_addr    = p0_addr;
      mem_wr_data = p0_wr_data;
    end else if (w_p1_gnt) begin
      mem_wr_sel  = p1_wr_sel;
      mem_addr    = p1_addr;
      mem_wr_data = p1_wr_data;
    end
  end

  assign w_rd_grant = (w_p0_gnt && p0_wr_sel == 4'b0) ||
                      (w_p1_gnt && p1_wr_sel == 4'b0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ARB;
      r_wait_cnt     <= 4'b0;
      r_rd_pend      <= 1'b0;
      r_rd_pend_port <= 1'b0;
    end else begin
      r_rd_pend      <= w_rd_grant;
      r_rd_pend_port <= w_p1_gnt;

      if (!p1_req || w_p1_gnt) begin
        r_wait_cnt <= 4'b0;
      end else if (r_wait_cnt < LP_MAX_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end

      case (r_state)
        ARB: begin
          if (P1_LOCK_EN && w_p1_gnt && p1_lock) begin
            r_state <= LOCK1;
          end
        end
        LOCK1: begin
          // On lock release the grant this cycle already followed ARB rules.
          if (!p1_lock) begin
            r_state <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign p0_rd_valid = r_rd_pend && !r_rd_pend_port;
  assign p1_rd_valid = r_rd_pend && r_rd_pend_port;
  assign p0_rd_data  = p0_rd_valid ? mem_rd_data : 32'b0;
  assign p1_rd_data  = p1_rd_valid ? mem_rd_data : 32'b0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: per-cycle grant/mem-drive checks plus a
// read-data scoreboard drained by an independent monitor.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p1_req, p1_lock;
  logic [3:0]  p0_wr_sel, p1_wr_sel;
  logic [31:0] p0_addr, p0_wr_data, p1_addr, p1_wr_data;
  logic        p0_gnt, p1_gnt, p0_rd_valid, p1_rd_valid;
  logic [31:0] p0_rd_data, p1_rd_data;
  logic [3:0]  mem_wr_sel;
  logic [31:0] mem_addr, mem_wr_data;
  logic [31:0] mem_rd_data = 32'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  data_mem_arbiter #(.MAX_WAIT(4), .P1_LOCK_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_wr_sel(p0_wr_sel), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
    .p0_gnt(p0_gnt), .p0_rd_valid(p0_rd_valid), .p0_rd_data(p0_rd_data),
    .p1_req(p1_req), .p1_wr_sel(p1_wr_sel), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
    .p1_gnt(p1_gnt), .p1_rd_valid(p1_rd_valid), .p1_rd_data(p1_rd_data),
    .p1_lock(p1_lock),
    .mem_wr_sel(mem_wr_sel), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  // Byte-enabled memory with registered 1-cycle read.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_wr_sel[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
    mem_rd_data <= mem[mem_addr[9:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r,
                      input logic q0r, input logic [3:0] s0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic q1r, input logic [3:0] s1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic lk, input logic e0, input logic e1, input string nm);
    logic [3:0]  esel;
    logic [31:0] eaddr;
    @(negedge clk);
    rst = r;
    p0_req = q0r; p0_wr_sel = s0; p0_addr = a0; p0_wr_data = d0;
    p1_req = q1r; p1_wr_sel = s1; p1_addr = a1; p1_wr_data = d1;
    p1_lock = lk;
    #1;
    esel  = e0 ? s0 : (e1 ? s1 : 4'b0);
    eaddr = e0 ? a0 : (e1 ? a1 : 32'b0);
    chk({nm, ".p0_gnt"}, {31'b0, p0_gnt}, {31'b0, e0});
    chk({nm, ".p1_gnt"}, {31'b0, p1_gnt}, {31'b0, e1});
    chk({nm, ".mem_wr_sel"}, {28'b0, mem_wr_sel}, {28'b0, esel});
    chk({nm, ".mem_addr"}, mem_addr, eaddr);
  endtask

  task automatic idle(input string nm);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  // Monitor: pop expected read data whenever a port presents rd_valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (p0_rd_valid) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL p0_rd_unexpected actual=%h required=no_valid", p0_rd_data);
        end else begin
          logic [31:0] e;
          e = q0.pop_front();
          if (p0_rd_data !== e) begin
            errors++;
            $display("FAIL p0_rd_data actual=%h required=%h", p0_rd_data, e);
          end
        end
      end else if (p0_rd_data !== 32'b0) begin
        checks++; errors++;
        $display("FAIL p0_rd_data_idle actual=%h required=0", p0_rd_data);
      end
      if (p1_rd_valid) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL p1_rd_unexpected actual=%h required=no_valid", p1_rd_data);
        end else begin
          logic [31:0] e;
          e = q1.pop_front();
          if (p1_rd_data !== e) begin
            errors++;
            $display("FAIL p1_rd_data actual=%h required=%h", p1_rd_data, e);
          end
        end
      end else if (p1_rd_data !== 32'b0) begin
        checks++; errors++;
        $display("FAIL p1_rd_data_idle actual=%h required=0", p1_rd_data);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'hDEADBEEF;   // 0x10
    mem[8'h08] = 32'h55667788;   // 0x20
    mem[8'h0C] = 32'hCAFE0030;   // 0x30
    rst = 1'b1;
    p0_req = 0; p0_wr_sel = 0; p0_addr = 0; p0_wr_data = 0;
    p1_req = 0; p1_wr_sel = 0; p1_addr = 0; p1_wr_data = 0; p1_lock = 0;

    // reset gates grants and memory writes
    step(1, 1, 4'hF, 32'h10, 32'hFFFFFFFF, 1, 4'h0, 32'h20, 0, 0, 0, 0, "rst_hold0");
    step(1, 1, 4'hF, 32'h10, 32'hFFFFFFFF, 0, 4'h0, 32'h0, 0, 0, 0, 0, "rst_hold1");

    // simple p0 read
    step(0, 1, 4'h0, 32'h10, 0, 0, 4'h0, 32'h0, 0, 0, 1, 0, "p0_read");
    q0.push_back(32'hDEADBEEF);

    // p0 partial write beats simultaneous p1 read, p1 follows
    step(0, 1, 4'b0011, 32'h20, 32'h1234ABCD, 1, 4'h0, 32'h20, 0, 0, 1, 0, "p0_wr_first");
    step(0, 0, 4'h0, 32'h0, 0, 1, 4'h0, 32'h20, 0, 0, 0, 1, "p1_rd_next");
    q1.push_back(32'h5566ABCD);
    idle("idle_a");

    // starvation: p1 denied 4 cycles, granted on the 5th, then p0 again
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 4'h0, 32'h10, 0, 1, 4'h0, 32'h30, 0, 0, 1, 0, $sformatf("starve%0d", i));
      q0.push_back(32'hDEADBEEF);
    end
    step(0, 1, 4'h0, 32'h10, 0, 1, 4'h0, 32'h30, 0, 0, 0, 1, "starve_force");
    q1.push_back(32'hCAFE0030);
    step(0, 1, 4'h0, 32'h10, 0, 1, 4'h0, 32'h30, 0, 0, 1, 0, "starve_after");
    q0.push_back(32'hDEADBEEF);
    idle("idle_b");

    // lock burst: 3 p1 writes, p0 shut out until lock drops
    step(0, 0, 4'h0, 32'h10, 0, 1, 4'hF, 32'h40, 32'h11111111, 1, 0, 1, "lock_w0");
    step(0, 1, 4'h0, 32'h10, 0, 1, 4'hF, 32'h44, 32'h22222222, 1, 0, 1, "lock_w1");
    step(0, 1, 4'h0, 32'h10, 0, 1, 4'hF, 32'h48, 32'h33333333, 1, 0, 1, "lock_w2");
    step(0, 1, 4'h0, 32'h10, 0, 0, 4'h0, 32'h0, 0, 0, 1, 0, "lock_release");
    q0.push_back(32'hDEADBEEF);
    step(0, 1, 4'h0, 32'h44, 0, 0, 4'h0, 32'h0, 0, 0, 1, 0, "lock_readback");
    q0.push_back(32'h22222222);
    idle("idle_c");

    // reset while in LOCK1 with a p1 read just granted
    step(0, 0, 4'h0, 32'h0, 0, 1, 4'h0, 32'h40, 0, 1, 0, 1, "lock_rd");
    step(1, 1, 4'h0, 32'h10, 0, 1, 4'h0, 32'h40, 0, 1, 0, 0, "rst_in_lock");
    step(0, 1, 4'h0, 32'h48, 0, 0, 4'h0, 32'h0, 0, 0, 1, 0, "post_rst_p0");
    q0.push_back(32'h33333333);

    // quiet bus
    for (int i = 0; i < 10; i++) idle($sformatf("quiet%0d", i));

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
